// File: rtl/angle_fire_gen.sv
// angle_fire_gen -- gate-pulse generator for a 6-pulse thyristor bridge.
//
// Takes the 10-bit line angle (0..1023 = one mains period) and a requested
// firing delay, and produces one gate pulse per channel per period. Each
// channel runs its own DISARMED -> ARMED -> PULSE machine: it is armed half a
// period ahead of its fire point and fires when the fire point is crossed, so
// it fires exactly once per period in either phase sequence and survives
// stalls and jumps of the angle input.
//
// Ports
//   clk        clock, single domain
//   RESET      synchronous, active-high reset
//   enable     0 = gates forced low, no firing (arming still tracks)
//   theta_in   line angle, may step +/-1, stall or jump
//   alpha_in   requested firing delay in angle counts (clamped to ALPHA_MAX)
//   gate       gate pulses, bit k = thyristor k
//   armed      bit k = channel k armed
//   alpha_act  firing delay in use for the current period
module angle_fire_gen #(
    parameter int PULSE_W   = 50,
    parameter int ALPHA_MAX = 853
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       enable,
    input  logic [9:0] theta_in,
    input  logic [9:0] alpha_in,
    output logic [5:0] gate,
    output logic [5:0] armed,
    output logic [9:0] alpha_act
);

    localparam logic [9:0]      AMAX    = 10'(ALPHA_MAX);
    localparam logic [7:0]      PW_LAST = 8'(PULSE_W - 1);
    // Base offsets of the six channels, 60 degrees apart.
    localparam logic [5:0][9:0] OFF     = {10'd853, 10'd683, 10'd512,
                                           10'd341, 10'd171, 10'd0};

    typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_PULSE} state_t;

    // True when point q lies in the arc swept this cycle. Forward motion
    // sweeps (prev, prev+d]; backward motion sweeps [prev-e, prev) with
    // e = 1024-d. The starting angle itself is never counted, so a point is
    // crossed on the cycle theta arrives at it.
    function automatic logic f_crossed(input logic [9:0] q,
                                       input logic [9:0] prev,
                                       input logic [9:0] d,
                                       input logic       fwd,
                                       input logic       bwd);
        logic [9:0] dq_f;
        logic [9:0] dq_b;
        dq_f = q - prev;
        dq_b = prev - q;
        return (fwd && (dq_f != 10'd0) && (dq_f <= d)) ||
               (bwd && (dq_b != 10'd0) && (dq_b <= (10'd0 - d)));
    endfunction

    logic       r_primed;
    logic [9:0] r_prev_theta;
    logic [9:0] r_alpha_act;

    logic [9:0] w_d;
    logic       w_fwd;
    logic       w_bwd;
    logic       w_zero_x;
    logic [9:0] w_alpha_clamp;

    assign w_d   = theta_in - r_prev_theta;
    // A step of exactly half a period has no defined direction: neither
    // flag is set, so nothing is crossed. The priming cycle is also blanked.
    assign w_fwd = r_primed && (w_d != 10'd0) && !w_d[9];
    assign w_bwd = r_primed && w_d[9] && (w_d[8:0] != 9'd0);

    assign w_zero_x      = f_crossed(10'd0, r_prev_theta, w_d, w_fwd, w_bwd);
    assign w_alpha_clamp = (alpha_in > AMAX) ? AMAX : alpha_in;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_primed     <= 1'b0;
            r_prev_theta <= 10'd0;
            r_alpha_act  <= AMAX;
        end else begin
            r_primed     <= 1'b1;
            r_prev_theta <= theta_in;
            // New delay only takes effect at the period boundary (angle 0),
            // so fire points never move mid-period.
            if (w_zero_x)
                r_alpha_act <= w_alpha_clamp;
        end
    end

    assign alpha_act = r_alpha_act;

    for (genvar k = 0; k < 6; k++) begin : g_ch
        logic [9:0] w_p;
        logic [9:0] w_r;
        logic       w_arm_x;
        logic       w_fire_x;
        state_t     r_state;
        state_t     w_state_nxt;
        logic [7:0] r_cnt;
        logic [7:0] w_cnt_nxt;

        assign w_p      = OFF[k] + r_alpha_act;
        assign w_r      = w_p + 10'd512;
        assign w_arm_x  = f_crossed(w_r, r_prev_theta, w_d, w_fwd, w_bwd);
        assign w_fire_x = f_crossed(w_p, r_prev_theta, w_d, w_fwd, w_bwd);

        always_ff @(posedge clk) begin
            if (RESET) begin
                r_state <= S_DISARMED;
                r_cnt   <= 8'd0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                S_DISARMED: begin
                    if (w_arm_x)
                        w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    // While disabled the channel stays armed, so it fires at
                    // the next fire point after enable returns.
                    if (w_fire_x && enable) begin
                        w_state_nxt = S_PULSE;
                        w_cnt_nxt   = 8'd0;
                    end
                end
                S_PULSE: begin
                    if (!enable || (r_cnt == PW_LAST)) begin
                        w_state_nxt = S_DISARMED;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_DISARMED;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end

        assign gate[k]  = (r_state == S_PULSE);
        assign armed[k] = (r_state == S_ARMED);
    end

endmodule
